prog_clk_div: RTL

PROG_CLK_DIV -- requirements
Module: prog_clk_div

---
 rtl/clk_div_pkg.sv | 15 +
 rtl/prog_clk_div_if.sv | 30 +++
 rtl/clk_div_ch.sv | 81 ++++++++
 rtl/prog_clk_div.sv | 49 ++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
// Holds the output-mode encoding, the divisor floor and a width helper.
package clk_div_pkg;

    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // Smallest period a channel can run at; smaller writes are raised to it.
    localparam int DIV_MIN = 2;

    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prog_clk_div_if.sv
// Configuration write port of the divider bank.
// Ports: wr_en strobe, wr_ch channel select, wr_div / wr_duty / wr_mode data.
interface prog_clk_div_if #(
    parameter int WIDTH = 32,
    parameter int CH_W  = 2
);

    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [WIDTH-1:0] wr_div;
    logic [WIDTH-1:0] wr_duty;
    logic             wr_mode;

    modport master (
        output wr_en,
        output wr_ch,
        output wr_div,
        output wr_duty,
        output wr_mode
    );

    modport slave (
        input wr_en,
        input wr_ch,
        input wr_div,
        input wr_duty,
        input wr_mode
    );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/pending configuration, output regs.
// Ports: clk, rst, en, sync, wr + wr_div/wr_duty/wr_mode in; out, tick out.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_div,
    input  logic [WIDTH-1:0] wr_duty,
    input  logic             wr_mode,
    output logic             out,
    output logic             tick
);

    typedef struct packed {
        logic [WIDTH-1:0] div;
        logic [WIDTH-1:0] duty;
        logic             mode;
    } cfg_t;

    localparam logic [WIDTH-1:0] DIV_FLOOR = WIDTH'(DIV_MIN);
    localparam cfg_t CFG_RST = '{
        div:  WIDTH'(DEFAULT_DIV),
        duty: WIDTH'(DEFAULT_DIV / 2),
        mode: MODE_SQUARE
    };

    cfg_t             act;
    cfg_t             pend;
    cfg_t             wr_cfg;
    logic [WIDTH-1:0] cnt;
    logic             last;
    logic             level;

    always_comb begin
        wr_cfg.div  = (wr_div < DIV_FLOOR) ? DIV_FLOOR : wr_div;
        wr_cfg.duty = wr_duty;
        wr_cfg.mode = wr_mode;
    end

    assign last  = (cnt == act.div - WIDTH'(1));
    assign level = (act.mode == MODE_PULSE) ? last : (cnt < act.duty);

    // The active set always takes the pending value from before this edge,
    // so a write landing in a wrap/sync cycle waits for the next wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            act  <= CFG_RST;
            pend <= CFG_RST;
            out  <= 1'b0;
            tick <= 1'b0;
        end else begin
            if (wr) begin
                pend <= wr_cfg;
            end
            if (!en) begin
                cnt  <= '0;
                act  <= pend;
                out  <= 1'b0;
                tick <= 1'b0;
            end else begin
                out  <= level;
                tick <= last;
                if (sync || last) begin
                    cnt <= '0;
                    act <= pend;
                end else begin
                    cnt <= cnt + WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/prog_clk_div.sv
// Bank of NUM_CH independent programmable clock dividers.
// Ports: clk, rst, en[NUM_CH], sync, cfg (write port); out, tick [NUM_CH].
module prog_clk_div
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    prog_clk_div_if.slave     cfg,
    output logic [NUM_CH-1:0] out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] wr_hit;

    // Out-of-range channel numbers match no index and fall through.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.wr_en && int'(cfg.wr_ch) == i) begin
                wr_hit[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_ch #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[g]),
            .sync    (sync),
            .wr      (wr_hit[g]),
            .wr_div  (cfg.wr_div),
            .wr_duty (cfg.wr_duty),
            .wr_mode (cfg.wr_mode),
            .out     (out[g]),
            .tick    (tick[g])
        );
    end

endmodule
